// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and helpers for the search-window memory arbiter
package mem_arb_pkg;

   // Requester index: loader is requester 0, PE-array fetch is requester 1
   typedef enum logic {
      REQ_LOADER = 1'b0,
      REQ_FETCH  = 1'b1
   } req_idx_e;

   localparam int NUM_REQ = 2;

   // Ceiling log2, used to size the burst counter
   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) begin
         result = result + 1;
      end
      return result;
   endfunction

   // Burst counter width, never narrower than one bit
   function automatic int cnt_width(input int burst_len);
      return (clog2(burst_len) < 1) ? 1 : clog2(burst_len);
   endfunction

   // The requester that is not the given one
   function automatic req_idx_e other_req(input req_idx_e idx);
      return (idx == REQ_LOADER) ? REQ_FETCH : REQ_LOADER;
   endfunction

endpackage

// File: rtl/mem_arb_rr_select.sv
// rtl/mem_arb_rr_select.sv - two-way round-robin pick producing a one-hot grant
module mem_arb_rr_select
   import mem_arb_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  req_idx_e           last,
   input  logic               keep,
   output logic [NUM_REQ-1:0] gnt
);

   req_idx_e prefer;
   req_idx_e alt;

   // Favour the last winner while its burst is still open, otherwise the other one;
   // fall back to the non-preferred requester so a lone requester never sees a bubble
   always_comb begin
      gnt    = '0;
      prefer = keep ? last : other_req(last);
      alt    = other_req(prefer);
      if (req[prefer]) begin
         gnt[prefer] = 1'b1;
      end else if (req[alt]) begin
         gnt[alt] = 1'b1;
      end
   end

endmodule

// File: rtl/mem_access_arbiter.sv
// rtl/mem_access_arbiter.sv - single-port search-window memory arbiter; MEM_ARB_BURST_EN enables burst grants
module mem_access_arbiter
   import mem_arb_pkg::*;
#(
   parameter int DWIDTH    = 8,
   parameter int AWIDTH    = 12,
   parameter int BURST_LEN = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [AWIDTH-1:0] addr0,
   input  logic [AWIDTH-1:0] addr1,
   input  logic [DWIDTH-1:0] wdata0,
   input  logic [DWIDTH-1:0] wdata1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              rvalid0,
   output logic              rvalid1,
   output logic [DWIDTH-1:0] rdata,
   output logic              mem_wren,
   output logic [AWIDTH-1:0] mem_address,
   output logic [DWIDTH-1:0] mem_data,
   input  logic [DWIDTH-1:0] mem_q
);

`ifdef MEM_ARB_BURST_EN
   localparam int EFF_BURST = BURST_LEN;
`else
   // Strict per-access round robin behaves as a burst of one; BURST_LEN has no effect
   localparam int EFF_BURST = (BURST_LEN >= 1) ? 1 : 1;
`endif

   localparam int CW = cnt_width(EFF_BURST);

   req_idx_e             last_q, last_d;
   logic                 keep_q, keep_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [NUM_REQ-1:0]   rvalid_q, rvalid_d;
   logic [NUM_REQ-1:0]   req_v;
   logic [NUM_REQ-1:0]   sel_gnt;
   logic [NUM_REQ-1:0]   gnt;
   req_idx_e             win;

   assign req_v = {req1, req0};

   mem_arb_rr_select u_rr_select (
      .req  (req_v),
      .last (last_q),
      .keep (keep_q),
      .gnt  (sel_gnt)
   );

   // Grants are suppressed while reset is held; the granted port drives the memory
   always_comb begin
      gnt         = reset ? '0 : sel_gnt;
      mem_wren    = 1'b0;
      mem_address = '0;
      mem_data    = '0;
      if (gnt[REQ_LOADER]) begin
         mem_wren    = we0;
         mem_address = addr0;
         mem_data    = wdata0;
      end else if (gnt[REQ_FETCH]) begin
         mem_wren    = we1;
         mem_address = addr1;
         mem_data    = wdata1;
      end
   end

   // Pointer, burst state and read-valid pipeline for the next cycle
   always_comb begin
      last_d   = last_q;
      keep_d   = 1'b0;
      cnt_d    = '0;
      win      = gnt[REQ_FETCH] ? REQ_FETCH : REQ_LOADER;
      rvalid_d = {gnt[REQ_FETCH] & ~we1, gnt[REQ_LOADER] & ~we0};
      if (|gnt) begin
         last_d = win;
         if ((win == last_q) && keep_q) begin
            cnt_d = cnt_q + 1'b1;
         end else begin
            cnt_d = '0;
         end
         keep_d = (int'(cnt_d) < (EFF_BURST - 1));
      end
   end

   // State registers; reset returns priority to requester 0 and drops in-flight reads
   always_ff @(posedge clock) begin
      if (reset) begin
         last_q   <= REQ_FETCH;
         keep_q   <= 1'b0;
         cnt_q    <= '0;
         rvalid_q <= '0;
      end else begin
         last_q   <= last_d;
         keep_q   <= keep_d;
         cnt_q    <= cnt_d;
         rvalid_q <= rvalid_d;
      end
   end

   assign gnt0    = gnt[REQ_LOADER];
   assign gnt1    = gnt[REQ_FETCH];
   assign rvalid0 = rvalid_q[REQ_LOADER];
   assign rvalid1 = rvalid_q[REQ_FETCH];
   assign rdata   = mem_q;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// tb/tb_mem_access_arbiter.sv - directed self-checking bench for mem_access_arbiter
module tb_mem_access_arbiter;

   logic        clock;
   logic        reset;
   logic        req0, req1, we0, we1;
   logic [11:0] addr0, addr1;
   logic [7:0]  wdata0, wdata1;
   logic        gnt0, gnt1, rvalid0, rvalid1;
   logic [7:0]  rdata;
   logic        mem_wren;
   logic [11:0] mem_address;
   logic [7:0]  mem_data;
   logic [7:0]  mem_q;

   logic [7:0]  mem [0:4095];

   int vec_cnt;
   int err_cnt;

   mem_access_arbiter #(.DWIDTH(8), .AWIDTH(12), .BURST_LEN(4)) dut (
      .clock       (clock),
      .reset       (reset),
      .req0        (req0),
      .req1        (req1),
      .we0         (we0),
      .we1         (we1),
      .addr0       (addr0),
      .addr1       (addr1),
      .wdata0      (wdata0),
      .wdata1      (wdata1),
      .gnt0        (gnt0),
      .gnt1        (gnt1),
      .rvalid0     (rvalid0),
      .rvalid1     (rvalid1),
      .rdata       (rdata),
      .mem_wren    (mem_wren),
      .mem_address (mem_address),
      .mem_data    (mem_data),
      .mem_q       (mem_q)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Single-port memory with registered read
   always @(posedge clock) begin
      if (mem_wren) mem[mem_address] <= mem_data;
      mem_q <= mem[mem_address];
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         vec_cnt++;
         if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_gnt cyc%0d: got %b%b expected 00", i, gnt1, gnt0);
         end
         vec_cnt++;
         if (mem_wren !== 1'b0 || mem_address !== 12'h000) begin
            err_cnt++;
            $display("FAIL reset_mem cyc%0d: got wren=%b addr=%h expected 0/000", i, mem_wren, mem_address);
         end
         vec_cnt++;
         if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_rvalid cyc%0d: got %b%b expected 00", i, rvalid1, rvalid0);
         end
      end
      reset = 1'b0;
      req0 = 1'b0; req1 = 1'b0;
      step();
   endtask

   task automatic test_single_read();
      req1 = 1'b1; we1 = 1'b0; addr1 = 12'h010;
      #1;
      vec_cnt++;
      if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin
         err_cnt++;
         $display("FAIL single_read_gnt: got %b%b expected 10", gnt1, gnt0);
      end
      vec_cnt++;
      if (mem_address !== 12'h010 || mem_wren !== 1'b0) begin
         err_cnt++;
         $display("FAIL single_read_mem: got addr=%h wren=%b expected 010/0", mem_address, mem_wren);
      end
      step();
      req1 = 1'b0;
      #1;
      vec_cnt++;
      if (rvalid1 !== 1'b1 || rvalid0 !== 1'b0 || rdata !== 8'h5A) begin
         err_cnt++;
         $display("FAIL single_read_data: got rv=%b%b rdata=%h expected 10/5a", rvalid1, rvalid0, rdata);
      end
      step();
   endtask

   task automatic test_write_then_read();
      req0 = 1'b1; we0 = 1'b1; addr0 = 12'h123; wdata0 = 8'hA5;
      #1;
      vec_cnt++;
      if (gnt0 !== 1'b1 || mem_wren !== 1'b1 || mem_address !== 12'h123 || mem_data !== 8'hA5) begin
         err_cnt++;
         $display("FAIL write_drive: got gnt0=%b wren=%b addr=%h data=%h expected 1/1/123/a5",
                  gnt0, mem_wren, mem_address, mem_data);
      end
      step();
      req0 = 1'b0; we0 = 1'b0;
      req1 = 1'b1; we1 = 1'b0; addr1 = 12'h123;
      #1;
      vec_cnt++;
      if (gnt1 !== 1'b1 || rvalid0 !== 1'b0) begin
         err_cnt++;
         $display("FAIL raw_read_gnt: got gnt1=%b rvalid0=%b expected 1/0", gnt1, rvalid0);
      end
      step();
      req1 = 1'b0;
      #1;
      vec_cnt++;
      if (rvalid1 !== 1'b1 || rdata !== 8'hA5) begin
         err_cnt++;
         $display("FAIL raw_read_data: got rvalid1=%b rdata=%h expected 1/a5", rvalid1, rdata);
      end
      step();
   endtask

   task automatic test_contention();
      logic [8:0] exp_gnt1;
      int         ncyc;
`ifdef MEM_ARB_BURST_EN
      exp_gnt1 = 9'b011110000;
      ncyc = 9;
`else
      exp_gnt1 = 9'b000101010;
      ncyc = 6;
`endif
      req0 = 1'b1; we0 = 1'b1; addr0 = 12'h200; wdata0 = 8'h33;
      req1 = 1'b1; we1 = 1'b0; addr1 = 12'h345;
      for (int i = 0; i < ncyc; i++) begin
         #1;
         vec_cnt++;
         if (gnt1 !== exp_gnt1[i] || gnt0 !== ~exp_gnt1[i]) begin
            err_cnt++;
            $display("FAIL contention_gnt cyc%0d: got %b%b expected %b%b",
                     i, gnt1, gnt0, exp_gnt1[i], ~exp_gnt1[i]);
         end
         if (i > 0) begin
            vec_cnt++;
            if (rvalid1 !== exp_gnt1[i-1] || rvalid0 !== 1'b0) begin
               err_cnt++;
               $display("FAIL contention_rvalid cyc%0d: got %b%b expected %b0",
                        i, rvalid1, rvalid0, exp_gnt1[i-1]);
            end
            if (exp_gnt1[i-1]) begin
               vec_cnt++;
               if (rdata !== 8'h45) begin
                  err_cnt++;
                  $display("FAIL contention_rdata cyc%0d: got %h expected 45", i, rdata);
               end
            end
         end
         step();
      end
      req0 = 1'b0; req1 = 1'b0; we0 = 1'b0;
      #1;
      vec_cnt++;
      if (rvalid1 !== exp_gnt1[ncyc-1]) begin
         err_cnt++;
         $display("FAIL contention_last_rvalid: got %b expected %b", rvalid1, exp_gnt1[ncyc-1]);
      end
      step();
      vec_cnt++;
      if (mem[12'h200] !== 8'h33) begin
         err_cnt++;
         $display("FAIL contention_write: got %h expected 33", mem[12'h200]);
      end
   endtask

   task automatic test_reset_mid();
      step();
      req0 = 1'b1; we0 = 1'b0; addr0 = 12'h010;
      #1;
      vec_cnt++;
      if (gnt0 !== 1'b1) begin
         err_cnt++;
         $display("FAIL mid_reset_pre_gnt: got %b expected 1", gnt0);
      end
      step();
      req0 = 1'b0;
      reset = 1'b1;
      #1;
      vec_cnt++;
      if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
         err_cnt++;
         $display("FAIL mid_reset_gnt: got %b%b expected 00", gnt1, gnt0);
      end
      step();
      reset = 1'b0;
      req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
      addr0 = 12'h010; addr1 = 12'h010;
      #1;
      vec_cnt++;
      if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin
         err_cnt++;
         $display("FAIL mid_reset_rvalid: got %b%b expected 00", rvalid1, rvalid0);
      end
      vec_cnt++;
      if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
         err_cnt++;
         $display("FAIL mid_reset_ptr: got %b%b expected 01", gnt1, gnt0);
      end
      step();
      req0 = 1'b0; req1 = 1'b0;
      step();
   endtask

   initial begin
      vec_cnt = 0;
      err_cnt = 0;
      for (int i = 0; i < 4096; i++) mem[i] = i[7:0];
      mem[12'h010] = 8'h5A;
      mem_q  = 8'h00;
      reset  = 1'b1;
      req0   = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
      addr0  = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
      test_reset();
      test_single_read();
      test_write_then_read();
      test_contention();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
